// File: rtl/reaction_ctrl.sv
// reaction_ctrl: sequencing FSM for the reaction-timer game.
//   Conditions the raw Start/Stop buttons (2-FF sync, debounce, press edge),
//   drives the 2-bit state bus to the datapath, and flags false starts and
//   timeouts.
// Ports:
//   Clock    in   system clock, shared with the datapath
//   Resetn   in   synchronous active-low reset
//   Start_n  in   raw Start button, active-low, asynchronous
//   Stop_n   in   raw Stop button, active-low, asynchronous
//   FLAG     in   datapath "random delay elapsed" (registered upstream)
//   state    out  0 IDLE, 1 WAIT, 2 COUNT, 3 HOLD
//   Early    out  Stop pressed during WAIT; held in HOLD
//   Timeout  out  COUNT ran to MAX_COUNT without Stop; held in HOLD
//   Busy     out  state is WAIT or COUNT
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for Start
// WAIT  | random delay running; Stop here is a false start
// COUNT | counting reaction cycles until Stop or MAX_COUNT
// HOLD  | result frozen on the display until the next Start
module reaction_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_COUNT       = 99
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start_n,
  input  logic       Stop_n,
  input  logic       FLAG,
  output logic [1:0] state,
  output logic       Early,
  output logic       Timeout,
  output logic       Busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam int            DW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_TC = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]    CNT_TC = 7'(MAX_COUNT - 1);

  // Bit 0 is Start, bit 1 is Stop; both buttons share one conditioning path.
  logic [1:0]    w_raw;
  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_deb;
  logic [1:0]    r_deb_d;
  logic [DW-1:0] r_dcnt [2];
  logic [1:0]    w_press;
  logic          w_start_ev;
  logic          w_stop_ev;

  logic [1:0]    r_state;
  logic          r_early;
  logic          r_timeout;
  logic [6:0]    r_ccnt;

  assign w_raw = {Stop_n, Start_n};

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_s1    <= '1;
      r_s2    <= '1;
      r_deb   <= '1;
      r_deb_d <= '1;
      for (int i = 0; i < 2; i++) begin
        r_dcnt[i] <= '0;
      end
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DEB_TC) begin
          r_deb[i]  <= r_s2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  // Falling edge of the debounced (active-low) level = one press event.
  assign w_press    = r_deb_d & ~r_deb;
  assign w_start_ev = w_press[0];
  assign w_stop_ev  = w_press[1];

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state   <= S_IDLE;
      r_early   <= 1'b0;
      r_timeout <= 1'b0;
      r_ccnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ev) begin
            r_state   <= S_WAIT;
            r_early   <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        S_WAIT: begin
          // A Stop in the same cycle as FLAG is still a false start.
          if (w_stop_ev) begin
            r_state <= S_HOLD;
            r_early <= 1'b1;
          end else if (FLAG) begin
            r_state <= S_COUNT;
            r_ccnt  <= '0;
          end
        end
        S_COUNT: begin
          r_ccnt <= r_ccnt + 1'b1;
          if (w_stop_ev) begin
            r_state <= S_HOLD;
          end else if (r_ccnt == CNT_TC) begin
            r_state   <= S_HOLD;
            r_timeout <= 1'b1;
          end
        end
        S_HOLD: begin
          if (w_start_ev) begin
            r_state   <= S_IDLE;
            r_early   <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign state   = r_state;
  assign Early   = r_early;
  assign Timeout = r_timeout;
  assign Busy    = (r_state == S_WAIT) || (r_state == S_COUNT);

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl: directed bench for reaction_ctrl with DEBOUNCE_CYCLES=2,
// MAX_COUNT=99. Inputs change and outputs are sampled on the falling edge.
module tb_reaction_ctrl;

  logic       Clock;
  logic       Resetn;
  logic       Start_n;
  logic       Stop_n;
  logic       FLAG;
  logic [1:0] state;
  logic       Early;
  logic       Timeout;
  logic       Busy;

  int n_total = 0;
  int n_bad   = 0;

  reaction_ctrl #(.DEBOUNCE_CYCLES(2), .MAX_COUNT(99)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Start_n (Start_n),
    .Stop_n  (Stop_n),
    .FLAG    (FLAG),
    .state   (state),
    .Early   (Early),
    .Timeout (Timeout),
    .Busy    (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Press Start from IDLE; WAIT is visible D+3 falling edges later.
  task automatic go_wait(input string tag);
    Start_n = 1'b0;
    cyc(5);
    chk(tag, 8'(state), 8'd1);
    Start_n = 1'b1;
    cyc(6);
  endtask

  // Press Start from HOLD; expect IDLE with both flags cleared.
  task automatic to_idle(input string tag);
    Start_n = 1'b0;
    cyc(5);
    chk({tag, "_state"}, 8'(state), 8'd0);
    chk({tag, "_early"}, 8'(Early), 8'd0);
    chk({tag, "_tmo"},   8'(Timeout), 8'd0);
    Start_n = 1'b1;
    cyc(6);
  endtask

  initial begin
    int cnt;
    Resetn  = 1'b0;
    Start_n = 1'b1;
    Stop_n  = 1'b1;
    FLAG    = 1'b0;
    cyc(3);
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_early", 8'(Early), 8'd0);
    chk("rst_tmo",   8'(Timeout), 8'd0);
    chk("rst_busy",  8'(Busy), 8'd0);

    // 1: quiet after reset release
    Resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (state != 2'd0 || Busy || Early || Timeout) cnt++;
    end
    chk("idle_50", 8'(cnt), 8'd0);

    // 2: normal game
    Start_n = 1'b0;
    cyc(4);
    chk("t2_lat_pre", 8'(state), 8'd0);
    cyc(1);
    chk("t2_wait", 8'(state), 8'd1);
    chk("t2_busy_w", 8'(Busy), 8'd1);
    cyc(5);
    Start_n = 1'b1;
    cyc(10);
    chk("t2_still_wait", 8'(state), 8'd1);
    FLAG = 1'b1;
    cyc(1);
    chk("t2_count", 8'(state), 8'd2);
    chk("t2_busy_c", 8'(Busy), 8'd1);
    cyc(36);
    Stop_n = 1'b0;
    cyc(4);
    chk("t2_count_pre", 8'(state), 8'd2);
    cyc(1);
    chk("t2_hold", 8'(state), 8'd3);
    chk("t2_early", 8'(Early), 8'd0);
    chk("t2_tmo", 8'(Timeout), 8'd0);
    chk("t2_busy_h", 8'(Busy), 8'd0);
    cyc(5);
    Stop_n = 1'b1;
    FLAG   = 1'b0;
    cyc(6);
    to_idle("t2_idle");

    // 3: false start, Stop event coincides with FLAG
    go_wait("t3_wait");
    Stop_n = 1'b0;
    cyc(4);
    chk("t3_wait_pre", 8'(state), 8'd1);
    FLAG = 1'b1;
    cyc(1);
    chk("t3_hold", 8'(state), 8'd3);
    chk("t3_early", 8'(Early), 8'd1);
    chk("t3_tmo", 8'(Timeout), 8'd0);
    cyc(5);
    chk("t3_early_held", 8'(Early), 8'd1);
    Stop_n = 1'b1;
    FLAG   = 1'b0;
    cyc(6);
    to_idle("t3_idle");

    // 4: timeout after exactly MAX_COUNT cycles in COUNT
    go_wait("t4_wait");
    FLAG = 1'b1;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      cyc(1);
      if (state == 2'd2) cnt++;
      else break;
    end
    chk("t4_count_len", 8'(cnt), 8'd99);
    chk("t4_hold", 8'(state), 8'd3);
    chk("t4_tmo", 8'(Timeout), 8'd1);
    chk("t4_early", 8'(Early), 8'd0);
    FLAG = 1'b0;
    cyc(2);
    to_idle("t4_idle");

    // Stop on the same cycle as the terminal count: Stop wins
    go_wait("tb_wait");
    FLAG = 1'b1;
    cyc(95);
    Stop_n = 1'b0;
    cyc(4);
    chk("tb_count_pre", 8'(state), 8'd2);
    cyc(1);
    chk("tb_hold", 8'(state), 8'd3);
    chk("tb_tmo", 8'(Timeout), 8'd0);
    chk("tb_early", 8'(Early), 8'd0);
    Stop_n = 1'b1;
    FLAG   = 1'b0;
    cyc(6);
    to_idle("tb_idle");

    // 5: one-cycle glitch ignored, long hold gives one transition
    Start_n = 1'b0;
    cyc(1);
    Start_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (state != 2'd0) cnt++;
    end
    chk("t5_glitch", 8'(cnt), 8'd0);
    Start_n = 1'b0;
    cyc(4);
    chk("t5_lat_pre", 8'(state), 8'd0);
    cyc(1);
    chk("t5_wait", 8'(state), 8'd1);
    cnt = 0;
    for (int i = 0; i < 195; i++) begin
      cyc(1);
      if (state != 2'd1) cnt++;
    end
    chk("t5_single", 8'(cnt), 8'd0);
    Start_n = 1'b1;
    cyc(6);
    FLAG = 1'b1;
    cyc(1);
    chk("t6_count", 8'(state), 8'd2);
    cyc(10);

    // 6: reset during COUNT with Stop held
    Stop_n = 1'b0;
    cyc(2);
    Resetn = 1'b0;
    cyc(1);
    Resetn = 1'b1;
    chk("t6_state", 8'(state), 8'd0);
    chk("t6_early", 8'(Early), 8'd0);
    chk("t6_tmo", 8'(Timeout), 8'd0);
    chk("t6_busy", 8'(Busy), 8'd0);
    chk("t6_ccnt", 8'(dut.r_ccnt), 8'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (dut.w_stop_ev) cnt++;
      if (state != 2'd0) cnt = cnt + 100;
    end
    chk("t6_one_ev_idle", 8'(cnt), 8'd1);
    Stop_n = 1'b1;
    FLAG   = 1'b0;
    cyc(5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
